rf_spill_engine: RTL and testbench
==================================

Name: rf_spill_engine

Overview:
- Sequencer that saves register-file contents to data memory (save) or reloads them from memory (restore) on a single start request.
- Acts as the initiator on the register file's read and write ports, and on the data-memory port.
- Used for context save/restore around subroutine-style sequences.
- Sits beside the controller; the top-level muxes its RF/memory signals in while busy_o=1.

Parameters:
raw, 4, RF address width; the RF holds 2**raw 8-bit registers
aw, 8, data-memory byte address width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
start_i  input  1  one-cycle request; sampled only in IDLE
mode_i  input  1  0=save (RF->mem), 1=restore (mem->RF); sampled with start_i
base_addr_i  input  aw  memory address of register 0's slot; sampled with start_i
count_i  input  raw+1  number of registers to transfer (0..2**raw); sampled with start_i
rf_rd_addr_o  output  raw  RF read pointer
rf_rd_data_i  input  8  RF read data; combinational from rf_rd_addr_o
rf_wr_addr_o  output  raw  RF write pointer
rf_wen_o  output  1  RF register write enable
rf_wr_data_o  output  8  RF write data
mem_addr_o  output  aw  data-memory address
mem_wen_o  output  1  data-memory write enable
mem_wr_data_o  output  8  data-memory write data
mem_rd_data_i  input  8  data-memory read data; valid one cycle after the address is presented (synchronous read)
busy_o  output  1  high from the cycle after start acceptance until the last transfer cycle, inclusive
done_o  output  1  one-cycle pulse after completion

Behaviour:
- States: IDLE, SAVE, RLOAD, DONE.
- Reset (synchronous, priority over everything):
  - State goes to IDLE; index and count registers clear.
  - All outputs are 0: addresses, data, wen, busy_o, done_o.
  - Reset mid-operation aborts immediately; no RF or memory write occurs in the reset cycle or after it.
- Counts: effective count n = min(count_i, 2**raw), latched at start. Index i runs 0..n-1.
- IDLE:
  - start_i=1 and n=0: go to DONE; no transfers.
  - start_i=1, mode_i=0: go to SAVE.
  - start_i=1, mode_i=1: go to RLOAD.
  - Otherwise stay in IDLE.
- SAVE (one register per cycle, n cycles total):
  - Each cycle: rf_rd_addr_o=i, mem_addr_o=(base+i) mod 2**aw, mem_wr_data_o=rf_rd_data_i (combinational pass-through), mem_wen_o=1.
  - After i=n-1, go to DONE.
- RLOAD (pipelined, n+1 cycles total):
  - Cycle k, for k<n: mem_addr_o=(base+k) mod 2**aw.
  - Cycle k, for k>=1: rf_wen_o=1, rf_wr_addr_o=k-1, rf_wr_data_o=mem_rd_data_i.
  - After the cycle that writes register n-1, go to DONE.
  - mem_wen_o stays 0 throughout.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o=0.
- busy_o=1 in SAVE and RLOAD only.
- start_i asserted outside IDLE is ignored; it is not queued.
- Memory address wraps modulo 2**aw; e.g. base=0xFE, n=4 uses 0xFE, 0xFF, 0x00, 0x01.
- Enables are 0 whenever not actively transferring. Address and data outputs hold their last value when idle (don't-care to consumers).

Optional Feature:
- Macro: RF_SPILL_CHECKSUM_EN.
- When defined:
  - Adds output checksum_o (8 bits): running XOR of every byte transferred (SAVE: the written memory data; RLOAD: the written RF data).
  - Cleared when start is accepted; stable from the done_o cycle until the next start.
  - Reset clears it to 0.
- When not defined: no checksum_o port and no checksum logic.

Test Plan:
- Save full RF: RF[i]=0x10+i, base=0x40, count=16, mode=0 -> mem[0x40..0x4F]=0x10..0x1F. busy_o high 16 cycles; done_o pulses the next cycle.
- Restore with wrap: mem[0xFE]=0xAA, mem[0xFF]=0xBB, mem[0x00]=0xCC, base=0xFE, count=3, mode=1 -> RF[0..2]=AA, BB, CC. rf_wen_o high exactly 3 cycles, starting the cycle after the first address; busy_o high 4 cycles.
- Zero count: count=0 -> no mem_wen_o or rf_wen_o; done_o one cycle after start; busy_o never high.
- Count clamp plus ignored start: count=31 with raw=4 -> exactly 16 transfers. A start_i pulse mid-transfer causes no extra transfers and no second done_o.
- Reset mid-op: assert reset in cycle 5 of a 16-register save -> mem writes only for i=0..3; all outputs 0 next cycle; a new start afterwards runs normally.
- With RF_SPILL_CHECKSUM_EN: save RF[0..3]=0x01, 0x02, 0x04, 0x08 -> checksum_o=0x0F at done_o.

Source files
------------

// File: rtl/rf_spill_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_spill_engine_if                                        |
// | Description : Request, register-file and data-memory signals of the     |
// |               spill engine. RF_SPILL_CHECKSUM_EN adds checksum_o.        |
// | Revision    : 1.0                                                       |
// +--------------------------------------------------------------------------+
interface rf_spill_engine_if #(
    parameter int RAW = 4,
    parameter int AW  = 8
);
    logic           start_i;
    logic           mode_i;
    logic [AW-1:0]  base_addr_i;
    logic [RAW:0]   count_i;
    logic [RAW-1:0] rf_rd_addr_o;
    logic [7:0]     rf_rd_data_i;
    logic [RAW-1:0] rf_wr_addr_o;
    logic           rf_wen_o;
    logic [7:0]     rf_wr_data_o;
    logic [AW-1:0]  mem_addr_o;
    logic           mem_wen_o;
    logic [7:0]     mem_wr_data_o;
    logic [7:0]     mem_rd_data_i;
    logic           busy_o;
    logic           done_o;
`ifdef RF_SPILL_CHECKSUM_EN
    logic [7:0]     checksum_o;
`endif

    modport master (
`ifdef RF_SPILL_CHECKSUM_EN
        output checksum_o,
`endif
        input  start_i, mode_i, base_addr_i, count_i, rf_rd_data_i, mem_rd_data_i,
        output rf_rd_addr_o, rf_wr_addr_o, rf_wen_o, rf_wr_data_o,
        output mem_addr_o, mem_wen_o, mem_wr_data_o, busy_o, done_o
    );

    modport slave (
`ifdef RF_SPILL_CHECKSUM_EN
        input  checksum_o,
`endif
        output start_i, mode_i, base_addr_i, count_i, rf_rd_data_i, mem_rd_data_i,
        input  rf_rd_addr_o, rf_wr_addr_o, rf_wen_o, rf_wr_data_o,
        input  mem_addr_o, mem_wen_o, mem_wr_data_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/rf_spill_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_spill_engine                                           |
// | Description : Saves RF registers to data memory or restores them, one   |
// |               per cycle. Optional macro RF_SPILL_CHECKSUM_EN.           |
// | Revision    : 1.0                                                       |
// +--------------------------------------------------------------------------+
module rf_spill_engine #(
    parameter int RAW = 4,
    parameter int AW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    rf_spill_engine_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SAVE  = 2'd1;
    localparam logic [1:0] S_RLOAD = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [RAW:0]   c_MAX_CNT = (RAW+1)'(2**RAW);
    localparam logic [RAW:0]   c_ONE     = (RAW+1)'(1);
    localparam logic [RAW-1:0] c_PTR_ONE = RAW'(1);

    logic [1:0]     r_state;
    logic [RAW:0]   r_idx;
    logic [RAW:0]   r_cnt;
    logic [AW-1:0]  r_base;
    logic [7:0]     r_mem_wdata;
    logic [7:0]     r_rf_wdata;
    logic [RAW-1:0] r_rf_waddr;

    logic [RAW:0]   w_start_cnt;
    logic           w_save;
    logic           w_rload;
    logic           w_rload_wr;
    logic [RAW-1:0] w_wr_addr;

    assign w_start_cnt = (bus.count_i > c_MAX_CNT) ? c_MAX_CNT : bus.count_i;
    assign w_save      = (r_state == S_SAVE);
    assign w_rload     = (r_state == S_RLOAD);
    // Restore is one cycle behind the memory address because reads are synchronous.
    assign w_rload_wr  = w_rload && (r_idx != '0);
    assign w_wr_addr   = r_idx[RAW-1:0] - c_PTR_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_base      <= '0;
            r_mem_wdata <= '0;
            r_rf_wdata  <= '0;
            r_rf_waddr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_cnt  <= w_start_cnt;
                        r_base <= bus.base_addr_i;
                        r_idx  <= '0;
                        if (w_start_cnt == '0)
                            r_state <= S_DONE;
                        else if (bus.mode_i)
                            r_state <= S_RLOAD;
                        else
                            r_state <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    r_idx       <= r_idx + c_ONE;
                    r_mem_wdata <= bus.rf_rd_data_i;
                    if (r_idx == r_cnt - c_ONE)
                        r_state <= S_DONE;
                end
                S_RLOAD: begin
                    r_idx <= r_idx + c_ONE;
                    if (w_rload_wr) begin
                        r_rf_wdata <= bus.mem_rd_data_i;
                        r_rf_waddr <= w_wr_addr;
                    end
                    if (r_idx == r_cnt)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RF_SPILL_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset)
            r_csum <= '0;
        else if (r_state == S_IDLE && bus.start_i)
            r_csum <= '0;
        else if (w_save)
            r_csum <= r_csum ^ bus.rf_rd_data_i;
        else if (w_rload_wr)
            r_csum <= r_csum ^ bus.mem_rd_data_i;
    end

    assign bus.checksum_o = r_csum;
`endif

    // Enables are gated by reset so an aborting cycle never writes.
    assign bus.mem_wen_o     = w_save && !reset;
    assign bus.rf_wen_o      = w_rload_wr && !reset;
    assign bus.rf_rd_addr_o  = r_idx[RAW-1:0];
    assign bus.mem_addr_o    = r_base + AW'(r_idx);
    assign bus.mem_wr_data_o = w_save ? bus.rf_rd_data_i : r_mem_wdata;
    assign bus.rf_wr_addr_o  = w_rload_wr ? w_wr_addr : r_rf_waddr;
    assign bus.rf_wr_data_o  = w_rload_wr ? bus.mem_rd_data_i : r_rf_wdata;
    assign bus.busy_o        = w_save || w_rload;
    assign bus.done_o        = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_rf_spill_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rf_spill_engine                                        |
// | Description : Directed bench for rf_spill_engine with RF/memory models  |
// |               and write scoreboards. Honours RF_SPILL_CHECKSUM_EN.      |
// | Revision    : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_rf_spill_engine;
    localparam int RAW = 4;
    localparam int AW  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_spill_engine_if #(.RAW(RAW), .AW(AW)) bus ();
    rf_spill_engine #(.RAW(RAW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0]  rf  [0:15];
    logic [7:0]  mem [0:255];
    logic [7:0]  mem_q;
    logic [15:0] exp_mem [$];
    logic [15:0] exp_rf  [$];
    logic [15:0] mon_e;
    int total = 0;
    int bad   = 0;
    int busy_n, done_n, mw_n, rw_n;
    int lat;
`ifdef RF_SPILL_CHECKSUM_EN
    logic [7:0] exp_ck;
`endif

    assign bus.rf_rd_data_i  = rf[bus.rf_rd_addr_o];
    assign bus.mem_rd_data_i = mem_q;

    always @(posedge clk) begin
        if (bus.rf_wen_o)  rf[bus.rf_wr_addr_o] <= bus.rf_wr_data_o;
        if (bus.mem_wen_o) mem[bus.mem_addr_o]  <= bus.mem_wr_data_o;
        mem_q <= mem[bus.mem_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write the DUT makes must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.busy_o) busy_n++;
        if (bus.done_o) done_n++;
        if (bus.mem_wen_o) begin
            mw_n++;
            check("mem_write_pending", 32'(exp_mem.size() > 0), 1);
            if (exp_mem.size() > 0) begin
                mon_e = exp_mem.pop_front();
                check("mem_write", {16'h0, bus.mem_addr_o, bus.mem_wr_data_o}, {16'h0, mon_e});
            end
        end
        if (bus.rf_wen_o) begin
            rw_n++;
            check("rf_write_pending", 32'(exp_rf.size() > 0), 1);
            if (exp_rf.size() > 0) begin
                mon_e = exp_rf.pop_front();
                check("rf_write", {20'h0, bus.rf_wr_addr_o, bus.rf_wr_data_o}, {16'h0, mon_e[11:0]});
            end
        end
    end

    task automatic push_mem(input logic [7:0] a, input logic [7:0] d);
        exp_mem.push_back({a, d});
`ifdef RF_SPILL_CHECKSUM_EN
        exp_ck ^= d;
`endif
    endtask

    task automatic push_rf(input logic [7:0] a, input logic [7:0] d);
        exp_rf.push_back({a, d});
`ifdef RF_SPILL_CHECKSUM_EN
        exp_ck ^= d;
`endif
    endtask

    task automatic prep();
        busy_n = 0; done_n = 0; mw_n = 0; rw_n = 0;
        exp_mem.delete();
        exp_rf.delete();
`ifdef RF_SPILL_CHECKSUM_EN
        exp_ck = 8'h00;
`endif
    endtask

    // Issues a start, optionally pulses start again in cycle inj, waits for done_o.
    task automatic run(input logic m, input logic [7:0] base, input logic [4:0] cnt, input int inj);
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.mode_i = m; bus.base_addr_i = base; bus.count_i = cnt;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = 1;
        while (!bus.done_o && lat < 100) begin
            bus.start_i = (lat == inj);
            @(posedge clk); #1;
            lat++;
        end
        bus.start_i = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int e_lat, input int e_busy, input int e_mw, input int e_rw);
        check({tag, "_done"}, bus.done_o, 1);
        check({tag, "_latency"}, lat, e_lat);
`ifdef RF_SPILL_CHECKSUM_EN
        check({tag, "_checksum"}, bus.checksum_o, exp_ck);
`endif
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, bus.done_o, 0);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_busy_cycles"}, busy_n, e_busy);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_mem_writes"}, mw_n, e_mw);
        check({tag, "_rf_writes"}, rw_n, e_rw);
        check({tag, "_left_mem"}, exp_mem.size(), 0);
        check({tag, "_left_rf"}, exp_rf.size(), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ctl"}, {bus.busy_o, bus.done_o, bus.mem_wen_o, bus.rf_wen_o}, 0);
        check({tag, "_addr"}, {bus.mem_addr_o, bus.rf_rd_addr_o, bus.rf_wr_addr_o}, 0);
        check({tag, "_data"}, {bus.mem_wr_data_o, bus.rf_wr_data_o}, 0);
`ifdef RF_SPILL_CHECKSUM_EN
        check({tag, "_checksum"}, bus.checksum_o, 0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.base_addr_i = '0; bus.count_i = '0;
        for (int i = 0; i < 16; i++)  rf[i]  = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        prep();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero("reset");

        // Save the full register file.
        prep();
        for (int i = 0; i < 16; i++) begin
            rf[i] = 8'h10 + 8'(i);
            push_mem(8'h40 + 8'(i), 8'h10 + 8'(i));
        end
        run(1'b0, 8'h40, 5'd16, -1);
        finish_run("save16", 17, 16, 16, 0);

        // Restore across the top of the address space.
        prep();
        mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC;
        push_rf(8'd0, 8'hAA); push_rf(8'd1, 8'hBB); push_rf(8'd2, 8'hCC);
        run(1'b1, 8'hFE, 5'd3, -1);
        finish_run("restore_wrap", 5, 4, 0, 3);

        // Zero count.
        prep();
        run(1'b0, 8'h10, 5'd0, -1);
        finish_run("zero", 1, 0, 0, 0);

        // Clamped count with an ignored mid-transfer start.
        prep();
        for (int i = 0; i < 16; i++) begin
            rf[i] = 8'(i * 7 + 3);
            push_mem(8'hF8 + 8'(i), 8'(i * 7 + 3));
        end
        run(1'b0, 8'hF8, 5'd31, 5);
        finish_run("clamp", 17, 16, 16, 0);

        // Reset during the fifth cycle of a 16-register save.
        prep();
        for (int i = 0; i < 16; i++) rf[i] = 8'h50 + 8'(i);
        for (int i = 0; i < 4; i++)  push_mem(8'h20 + 8'(i), 8'h50 + 8'(i));
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.mode_i = 1'b0; bus.base_addr_i = 8'h20; bus.count_i = 5'd16;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = 1;
        while (lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_zero("abort");
        check("abort_mem_writes", mw_n, 4);
        check("abort_left_mem", exp_mem.size(), 0);

        // Normal operation after the abort; checksum of 01^02^04^08.
        prep();
        rf[0] = 8'h01; rf[1] = 8'h02; rf[2] = 8'h04; rf[3] = 8'h08;
        push_mem(8'h30, 8'h01); push_mem(8'h31, 8'h02);
        push_mem(8'h32, 8'h04); push_mem(8'h33, 8'h08);
        run(1'b0, 8'h30, 5'd4, -1);
`ifdef RF_SPILL_CHECKSUM_EN
        check("post_abort_checksum_value", bus.checksum_o, 32'h0F);
`endif
        finish_run("post_abort", 5, 4, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
